// File: rtl/gcd_operand_packer.sv
// Operand packer feeding the GCD unit.
// Pairs consecutive 16-bit operands (first = A, second = B) into a 32-bit
// request {A,B} and queues it in a small circular FIFO. The FIFO head drives
// the GCD request port.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   recv_val/rdy/msg      16-bit operand stream in
//   send_val/rdy/msg      32-bit packed request out ([31:16]=A, [15:0]=B)
//   num_pairs             pairs enqueued since reset (wraps)
//   occupancy             current FIFO entry count
module gcd_operand_packer #(
    parameter int unsigned p_depth     = 2,
    parameter int unsigned p_cnt_nbits = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recv_val,
    output logic                         recv_rdy,
    input  logic [15:0]                  recv_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [31:0]                  send_msg,
    output logic [p_cnt_nbits-1:0]       num_pairs,
    output logic [$clog2(p_depth):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(p_depth);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {WAIT_A, WAIT_B} state_t;

    state_t             state;
    logic [15:0]        hold_a;
    logic [31:0]        storage [p_depth];
    logic [PTR_W-1:0]   enq_ptr;
    logic [PTR_W-1:0]   deq_ptr;
    logic               full;
    logic               enq;
    logic               deq;
    logic               take;

    // Handshake decode; recv_rdy may follow send_rdy when the FIFO is full,
    // which is loop-free because the GCD's ready ignores its valid.
    assign full     = (occupancy == OCC_W'(p_depth));
    assign send_val = (occupancy != '0);
    assign send_msg = storage[deq_ptr];
    assign deq      = send_val && send_rdy;
    assign recv_rdy = (state == WAIT_A) || !full || deq;
    assign take     = recv_val && recv_rdy;
    assign enq      = take && (state == WAIT_B);

    // Pairing FSM, pointers, occupancy and pair counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_A;
            enq_ptr   <= '0;
            deq_ptr   <= '0;
            occupancy <= '0;
            num_pairs <= '0;
        end else begin
            case (state)
                WAIT_A: if (take) state <= WAIT_B;
                WAIT_B: if (take) state <= WAIT_A;
                default: state <= WAIT_A;
            endcase

            if (enq) begin
                enq_ptr   <= (enq_ptr == PTR_W'(p_depth - 1)) ? '0 : enq_ptr + PTR_W'(1);
                num_pairs <= num_pairs + p_cnt_nbits'(1);
            end
            if (deq) begin
                deq_ptr <= (deq_ptr == PTR_W'(p_depth - 1)) ? '0 : deq_ptr + PTR_W'(1);
            end

            case ({enq, deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Data path: hold register and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (take && (state == WAIT_A)) hold_a <= recv_msg;
        if (enq) storage[enq_ptr] <= {hold_a, recv_msg};
    end

endmodule
